// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: collects a length-prefixed little-endian byte
// image, writes 32-bit words to the instruction memory and releases the CPU on a good checksum.
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_resetn
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned CMP_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state, w_state;
    logic [LEN_W-1:0]   r_len, w_len;
    logic [1:0]         r_byte_idx, w_byte_idx;
    logic [23:0]        r_shift, w_shift;
    logic [7:0]         r_csum, w_csum;
    logic               r_rx_ready, w_rx_ready;
    logic               r_wr_en, w_wr_en;
    logic [31:0]        r_wr_addr, w_wr_addr;
    logic [31:0]        r_wr_data, w_wr_data;
    logic [LEN_W-1:0]   r_word_count, w_word_count;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_error, w_error;
    logic               r_cpu_resetn, w_cpu_resetn;
    logic               w_hs;
    logic [LEN_W-1:0]   w_len_full;

    assign w_hs       = rx_valid && r_rx_ready;
    assign w_len_full = {rx_data, r_len[7:0]};

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state      = r_state;
        w_len        = r_len;
        w_byte_idx   = r_byte_idx;
        w_shift      = r_shift;
        w_csum       = r_csum;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_word_count = r_word_count;
        w_busy       = r_busy;
        w_done       = r_done;
        w_error      = r_error;
        w_cpu_resetn = r_cpu_resetn;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_state      = S_LEN_LO;
                    w_busy       = 1'b1;
                    w_done       = 1'b0;
                    w_error      = 1'b0;
                    w_word_count = '0;
                    w_csum       = '0;
                    w_byte_idx   = '0;
                    w_cpu_resetn = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (w_hs) begin
                    w_len[7:0] = rx_data;
                    w_state    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_hs) begin
                    w_len = w_len_full;
                    if (CMP_W'(w_len_full) > CMP_W'(MEM_SIZE)) begin
                        w_state      = S_ERROR;
                        w_busy       = 1'b0;
                        w_error      = 1'b1;
                        w_cpu_resetn = 1'b0;
                    end else if (w_len_full == '0) begin
                        w_state = S_CSUM;
                    end else begin
                        w_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    w_csum = r_csum + rx_data;
                    if (r_byte_idx == 2'd3) begin
                        // Fourth byte completes the word; the write fires from the register next cycle.
                        w_wr_en      = 1'b1;
                        w_wr_data    = {rx_data, r_shift};
                        w_wr_addr    = BASE_ADDR + 32'({r_word_count, 2'b00});
                        w_word_count = r_word_count + 16'd1;
                        w_byte_idx   = 2'd0;
                        if (w_word_count == r_len) begin
                            w_state = S_CSUM;
                        end
                    end else begin
                        w_shift[8*r_byte_idx +: 8] = rx_data;
                        w_byte_idx                 = r_byte_idx + 2'd1;
                    end
                end
            end
            S_CSUM: begin
                if (w_hs) begin
                    w_busy = 1'b0;
                    if (rx_data == r_csum) begin
                        w_state      = S_DONE;
                        w_done       = 1'b1;
                        w_cpu_resetn = 1'b1;
                    end else begin
                        w_state      = S_ERROR;
                        w_error      = 1'b1;
                        w_cpu_resetn = 1'b0;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_rx_ready = (w_state == S_LEN_LO) || (w_state == S_LEN_HI) ||
                     (w_state == S_DATA)   || (w_state == S_CSUM);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_csum       <= '0;
            r_rx_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_resetn <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_len        <= w_len;
            r_byte_idx   <= w_byte_idx;
            r_shift      <= w_shift;
            r_csum       <= w_csum;
            r_rx_ready   <= w_rx_ready;
            r_wr_en      <= w_wr_en;
            r_wr_addr    <= w_wr_addr;
            r_wr_data    <= w_wr_data;
            r_word_count <= w_word_count;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_error      <= w_error;
            r_cpu_resetn <= w_cpu_resetn;
        end
    end

    assign rx_ready   = r_rx_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_word_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign cpu_resetn = r_cpu_resetn;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of image loads plus reset/abort sequences,
// with a write scoreboard fed by the byte driver and drained by a write monitor.
module tb_imem_loader;

    localparam int unsigned MEM_SIZE  = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_resetn;

    imem_loader #(.MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_count(word_count), .busy(busy), .done(done),
        .error(error), .cpu_resetn(cpu_resetn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        int          nwords;
        logic [31:0] words [4];
        logic [7:0]  csum;
        bit          stall;
        bit          start_mid;
        bit          exp_done;
        bit          exp_error;
        logic [15:0] exp_wc;
        int          exp_writes;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] wc;
    } wr_t;

    vec_t vecs [6];
    wr_t  exp_q [$];
    int   n_vec;
    int   n_fail;
    int   n_wr;
    bit   prev_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sum_words(input vec_t v);
        logic [7:0] s;
        logic [31:0] w;
        s = 8'h00;
        for (int i = 0; i < v.nwords; i++) begin
            w = v.words[i];
            s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until a handshake edge has passed.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int cnt;
        if (stall) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        cnt = 0;
        while (!rx_ready && cnt < 200) begin
            tick();
            cnt++;
        end
        if (!rx_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL handshake_timeout: rx_ready stayed 0 for byte 0x%02h", b);
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_image(input vec_t v, input int max_bytes);
        int sent;
        logic [31:0] w;
        sent = 0;
        send_byte(v.n[7:0], v.stall);
        send_byte(v.n[15:8], v.stall);
        if (v.n > 16'(MEM_SIZE)) return;
        for (int i = 0; i < v.nwords; i++) begin
            w = v.words[i];
            for (int b = 0; b < 4; b++) begin
                if (sent == max_bytes) return;
                if (v.start_mid && sent == 5) pulse_start();
                if (b == 3) exp_q.push_back('{addr: BASE_ADDR + 32'(i * 4), data: w,
                                              wc: 16'(i + 1)});
                send_byte(w[8*b +: 8], v.stall);
                sent++;
            end
        end
        send_byte(v.csum, v.stall);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        n_wr = 0;
        pulse_start();
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        check({tag, "_cpurst_start"}, 32'(cpu_resetn), 32'd0);
        send_image(v, 1 << 30);
        tick();
        check({tag, "_done"}, 32'(done), 32'(v.exp_done));
        check({tag, "_error"}, 32'(error), 32'(v.exp_error));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'(v.exp_done));
        check({tag, "_word_count"}, 32'(word_count), 32'(v.exp_wc));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_writes"}, 32'(n_wr), 32'(v.exp_writes));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        wr_t e;
        n_vec = 0; n_fail = 0; n_wr = 0; prev_wr = 1'b0;
        resetn = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

        // Table of loads; 0x13 + 0x93 + 0x10 = 0xB6 is the good checksum of the two-word image.
        vecs[0] = '{n: 16'd2, nwords: 2, words: '{32'h0000_0013, 32'h0010_0093, 32'h0, 32'h0},
                    csum: 8'hB6, stall: 0, start_mid: 0, exp_done: 1, exp_error: 0, exp_wc: 16'd2, exp_writes: 2};
        vecs[1] = '{n: 16'd2, nwords: 2, words: '{32'h0000_0013, 32'h0010_0093, 32'h0, 32'h0},
                    csum: 8'hA7, stall: 0, start_mid: 0, exp_done: 0, exp_error: 1, exp_wc: 16'd2, exp_writes: 2};
        vecs[2] = '{n: 16'h0101, nwords: 0, words: '{32'h0, 32'h0, 32'h0, 32'h0},
                    csum: 8'h00, stall: 0, start_mid: 0, exp_done: 0, exp_error: 1, exp_wc: 16'd0, exp_writes: 0};
        vecs[3] = '{n: 16'd0, nwords: 0, words: '{32'h0, 32'h0, 32'h0, 32'h0},
                    csum: 8'h00, stall: 0, start_mid: 0, exp_done: 1, exp_error: 0, exp_wc: 16'd0, exp_writes: 0};
        vecs[4] = '{n: 16'd2, nwords: 2, words: '{32'h0000_0013, 32'h0010_0093, 32'h0, 32'h0},
                    csum: 8'hB6, stall: 1, start_mid: 1, exp_done: 1, exp_error: 0, exp_wc: 16'd2, exp_writes: 2};
        vecs[5] = '{n: 16'd4, nwords: 4, words: '{$urandom, $urandom, $urandom, $urandom},
                    csum: 8'h00, stall: 1, start_mid: 0, exp_done: 1, exp_error: 0, exp_wc: 16'd4, exp_writes: 4};
        vecs[5].csum = sum_words(vecs[5]);

        // Write monitor: pops the scoreboard on every strobe.
        fork
            forever begin
                @(posedge clk);
                #1;
                if (wr_en) begin
                    n_wr++;
                    if (prev_wr) begin
                        n_vec++; n_fail++;
                        $display("FAIL wr_back_to_back: wr_en high on consecutive cycles");
                    end
                    if (exp_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL wr_unexpected: addr 0x%08h data 0x%08h", wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                        check("wr_word_count", 32'(word_count), 32'(e.wc));
                    end
                end
                prev_wr = wr_en;
            end
        join_none

        repeat (3) tick();
        check("rst_outputs", {20'(0), rx_ready, wr_en, busy, done, error, cpu_resetn, 6'(0)}, 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        resetn = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_quiet", {29'(0), cpu_resetn, rx_ready, wr_en}, 32'd0);
        end
        rx_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort: reset after six payload bytes drops everything and discards the partial word.
        n_wr = 0;
        pulse_start();
        send_image(vecs[0], 6);
        resetn = 1'b0;
        #1;
        check("abort_outputs", {20'(0), rx_ready, wr_en, busy, done, error, cpu_resetn, 6'(0)}, 32'd0);
        check("abort_zero_bus", wr_addr | wr_data | 32'(word_count), 32'd0);
        check("abort_writes", 32'(n_wr), 32'd1);
        check("abort_pending", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        run_vec(vecs[0], 6);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
